// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and FSM state type for the sequential
// binary-to-BCD converter feeding the seven-segment scan display.
//   DIGITS      - BCD digits in the display word
//   BCD_W       - packed BCD width (4 bits per digit)
//   BCD_MAX     - largest value representable in DIGITS decimal digits
//   OVF_PATTERN - word shown when the input does not fit ('E' per digit)
package bcd_pkg;

    // 10^digits - 1, used to derive the overflow threshold for any width.
    function automatic longint bcd_max(input int digits);
        longint v;
        v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        return v - 1;
    endfunction

    localparam int                 DIGITS      = 8;
    localparam int                 BCD_W       = 4 * DIGITS;
    localparam longint             BCD_MAX     = bcd_max(DIGITS);
    localparam logic [BCD_W-1:0]   OVF_PATTERN = {DIGITS{4'hE}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: single-digit correction step of shift-and-add-3.
//   din  - current BCD nibble
//   dout - din + 3 when din >= 5, else din (4-bit, no carry out)
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative binary-to-BCD converter, one bit per clock.
// The last completed result is held on bcd_out so the display never
// sees a partial conversion.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - conversion request (ignored while shifting)
//   bin_in     - unsigned binary value, captured on accepted start
//   busy       - high in SHIFT and DONE
//   done       - one-cycle pulse when bcd_out/ovf update
//   bcd_out    - packed BCD, most significant digit in the top nibble
//   ovf        - input exceeded 10^DIGITS-1; bcd_out shows all 'E'
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 27,
    parameter int DIGITS = bcd_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int     OUT_W   = 4 * DIGITS;
    localparam int     SR_W    = OUT_W + BIN_W;
    localparam int     CNT_W   = $clog2(BIN_W + 1);
    localparam longint MAX_VAL = bcd_max(DIGITS);

    state_e                    state_q, state_d;
    logic [SR_W-1:0]           sr_q, sr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      flag_q, flag_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [OUT_W-1:0]          bcd_out_q, bcd_out_d;
    logic                      ovf_q, ovf_d;

    logic [DIGITS-1:0][3:0]    bcd_nib, bcd_adj;
    logic [SR_W-1:0]           sr_pre;

    // Per-digit correction on the accumulator half of the shift register.
    assign bcd_nib = sr_q[BIN_W +: OUT_W];

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_nib[g]),
            .dout (bcd_adj[g])
        );
    end

    // Corrected accumulator joined with the remaining binary bits; shifted
    // left by one in SHIFT.
    assign sr_pre = {bcd_adj, sr_q[BIN_W-1:0]};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        done_d    = 1'b0;
        bcd_out_d = bcd_out_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sr_d    = {{OUT_W{1'b0}}, bin_in};
                    cnt_d   = CNT_W'(BIN_W);
                    flag_d  = longint'(bin_in) > MAX_VAL;
                end
            end
            SHIFT: begin
                sr_d  = sr_pre << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                // Results publish on the edge leaving DONE, the same edge
                // that may capture a back-to-back request.
                bcd_out_d = flag_q ? {DIGITS{4'hE}} : sr_q[BIN_W +: OUT_W];
                ovf_d     = flag_q;
                done_d    = 1'b1;
                if (start) begin
                    state_d = SHIFT;
                    sr_d    = {{OUT_W{1'b0}}, bin_in};
                    cnt_d   = CNT_W'(BIN_W);
                    flag_d  = longint'(bin_in) > MAX_VAL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_out_q <= bcd_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_out_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed-vector bench for bin2bcd_seq with
// hand-computed BCD results.
module tb_bin2bcd_seq;

    localparam int BIN_W = 27;
    localparam int LAT   = BIN_W + 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [26:0] bin_in = '0;
    logic        busy, done, ovf;
    logic [31:0] bcd_out;

    int n_tests = 0;
    int n_fail  = 0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; returns 1 ns after the accepting edge E0.
    task automatic do_start(input logic [26:0] v);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat = edges after E0, 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic convert(input string tag, input logic [26:0] v,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        int lat;
        do_start(v);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        chk({tag, "_bcd"}, 64'(bcd_out), 64'(exp_bcd));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    endtask

    initial begin
        int lat, ndone, first, second;
        logic [31:0] v1, v2;
        int unstable;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd",  64'(bcd_out), 64'd0);
        chk("rst_ovf",  64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero, with busy and latency
        do_start(27'd0);
        chk("zero_busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("zero_lat", 64'(lat), 64'(LAT));
        chk("zero_bcd", 64'(bcd_out), 64'h0);
        chk("zero_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1;
        chk("zero_done_pulse", 64'(done), 64'd0);
        chk("zero_idle_busy", 64'(busy), 64'd0);

        convert("mid",   27'd12_345_678, 32'h1234_5678, 1'b0);
        convert("max",   27'd99_999_999, 32'h9999_9999, 1'b0);
        convert("over",  27'd100_000_000, 32'hEEEE_EEEE, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("over_hold", 64'(bcd_out), 64'hEEEE_EEEE);
        convert("seven", 27'd7, 32'h0000_0007, 1'b0);
        convert("top27", 27'd134_217_727, 32'hEEEE_EEEE, 1'b1);
        convert("mixed", 27'd90_909_090, 32'h9090_9090, 1'b0);

        // Start during SHIFT is ignored
        do_start(27'd10_000_000);
        ndone = 0;
        first = 0;
        v1    = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start  = (c == 10);
            bin_in = (c == 10) ? 27'd5 : 27'd0;
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = c;
                    v1    = bcd_out;
                end
            end
        end
        start = 1'b0;
        chk("ign_count", 64'(ndone), 64'd1);
        chk("ign_lat",   64'(first), 64'(LAT));
        chk("ign_bcd",   64'(v1), 64'h1000_0000);
        chk("ign_final", 64'(bcd_out), 64'h1000_0000);

        // Back-to-back with start held high
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd1;
        @(posedge clk);
        ndone = 0; first = 0; second = 0; unstable = 0;
        v1 = '0; v2 = '0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 1)  bin_in = 27'd2;
            if (c == 30) start  = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin first = c; v1 = bcd_out; end
                if (ndone == 2) begin second = c; v2 = bcd_out; end
            end else if (ndone == 1 && bcd_out !== 32'h1) begin
                unstable++;
            end
        end
        chk("b2b_count",  64'(ndone), 64'd2);
        chk("b2b_first",  64'(first), 64'(LAT));
        chk("b2b_period", 64'(second - first), 64'(LAT));
        chk("b2b_val1",   64'(v1), 64'h1);
        chk("b2b_val2",   64'(v2), 64'h2);
        chk("b2b_stable", 64'(unstable), 64'd0);

        // Reset mid-conversion
        do_start(27'd12_345_678);
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_bcd",  64'(bcd_out), 64'd0);
        chk("abort_ovf",  64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_nodone", 64'(ndone), 64'd0);
        convert("after", 27'd42, 32'h0000_0042, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
